// File: rtl/draw_board_grid_pkg.sv
// Shared board definitions: grid dimensions, colours and the pixel bus record
// carried through the draw_board_grid pipeline.
package board_pkg;

  localparam int GRID_SIZE = 10;
  localparam int COUNT_W   = 11;

  typedef logic [COUNT_W-1:0] count_t;
  typedef logic [11:0]        rgb_t;
  typedef logic [3:0]         cell_idx_t;

  localparam rgb_t DEFAULT_LINE_COLOR   = 12'hFFF;
  localparam rgb_t DEFAULT_CURSOR_COLOR = 12'hF00;
  localparam rgb_t BLANK_COLOR          = 12'h000;

  // One pixel of the VGA timing bus plus its colour, as it moves down the pipe.
  typedef struct packed {
    count_t hcount;
    count_t vcount;
    logic   hsync;
    logic   vsync;
    logic   hblank;
    logic   vblank;
    rgb_t   rgb;
  } pixel_t;

endpackage

// File: rtl/draw_board_grid_if.sv
// Pixel bus into and out of draw_board_grid: timing bus, colour and cell index.
// master drives the incoming pixel stream, slave is the drawing stage.
interface draw_board_grid_if;
  import board_pkg::*;

  count_t    hcount_in;
  count_t    vcount_in;
  logic      hsync_in;
  logic      vsync_in;
  logic      hblank_in;
  logic      vblank_in;
  rgb_t      rgb_in;

  count_t    hcount_out;
  count_t    vcount_out;
  logic      hsync_out;
  logic      vsync_out;
  logic      hblank_out;
  logic      vblank_out;
  rgb_t      rgb_out;
  cell_idx_t cell_x;
  cell_idx_t cell_y;
  logic      cell_valid;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblank_in, vblank_in, rgb_in,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblank_out, vblank_out,
    input  rgb_out, cell_x, cell_y, cell_valid
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblank_in, vblank_in, rgb_in,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblank_out, vblank_out,
    output rgb_out, cell_x, cell_y, cell_valid
  );

endinterface

// File: rtl/draw_board_grid_tracker.sv
// One axis of the board: tracks cell index and offset inside the cell by counting,
// so no division by CELL_SIZE is needed. Outputs are registered (pipeline stage 1).
module grid_axis_tracker
  import board_pkg::*;
#(
  parameter  int CELL_SIZE = 32,
  localparam int SUB_W     = $clog2(CELL_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  count_t           count,
  input  logic             step,
  input  count_t           pos,
  output cell_idx_t        idx,
  output logic [SUB_W-1:0] sub,
  output logic             valid
);

  typedef logic [COUNT_W:0] ext_t;

  localparam ext_t             SPAN     = ext_t'(GRID_SIZE * CELL_SIZE);
  localparam cell_idx_t        IDX_MAX  = cell_idx_t'(GRID_SIZE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_SIZE - 1);

  cell_idx_t        idx_q, idx_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic             valid_q, valid_d;
  logic             synced_q, synced_d;
  logic             load;
  logic             in_range;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    load     = (count == pos);
    in_range = (count >= pos) && (ext_t'(count) <= ext_t'(pos) + SPAN);
    idx_d    = idx_q;
    sub_d    = sub_q;
    synced_d = synced_q | load;
    // Until the first load after reset the counters mean nothing, so stay invalid.
    valid_d  = in_range && synced_d;

    if (load) begin
      idx_d = '0;
      sub_d = '0;
    end else if (step && in_range) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        if (idx_q != IDX_MAX) idx_d = idx_q + cell_idx_t'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      sub_q    <= '0;
      valid_q  <= 1'b0;
      synced_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      sub_q    <= sub_d;
      valid_q  <= valid_d;
      synced_q <= synced_d;
    end
  end

  assign idx   = idx_q;
  assign sub   = sub_q;
  assign valid = valid_q;

endmodule

// File: rtl/draw_board_grid.sv
// Overlays a GRID_SIZE x GRID_SIZE board grid on the pixel stream, two-cycle latency.
// Optional cell cursor highlight is enabled by defining BOARD_CURSOR_EN.
module draw_board_grid
  import board_pkg::*;
#(
  parameter int   X_POS      = 100,
  parameter int   Y_POS      = 50,
  parameter int   CELL_SIZE  = 32,
  parameter rgb_t LINE_COLOR = DEFAULT_LINE_COLOR
`ifdef BOARD_CURSOR_EN
  ,
  parameter rgb_t CURSOR_COLOR = DEFAULT_CURSOR_COLOR
`endif
) (
  input  logic               clk,
  input  logic               rst,
`ifdef BOARD_CURSOR_EN
  input  cell_idx_t          cursor_x,
  input  cell_idx_t          cursor_y,
`endif
  draw_board_grid_if.slave   bus
);

  localparam int        SUB_W   = $clog2(CELL_SIZE);
  localparam cell_idx_t IDX_MAX = cell_idx_t'(GRID_SIZE);

  cell_idx_t        idx_x, idx_y;
  logic [SUB_W-1:0] sub_x, sub_y;
  logic             valid_x, valid_y;

  grid_axis_tracker #(.CELL_SIZE(CELL_SIZE)) u_track_h (
    .clk   (clk),
    .rst   (rst),
    .count (bus.hcount_in),
    .step  (1'b1),
    .pos   (count_t'(X_POS)),
    .idx   (idx_x),
    .sub   (sub_x),
    .valid (valid_x)
  );

  // Vertical tracker advances once per line, on the first pixel of the line.
  grid_axis_tracker #(.CELL_SIZE(CELL_SIZE)) u_track_v (
    .clk   (clk),
    .rst   (rst),
    .count (bus.vcount_in),
    .step  (bus.hcount_in == '0),
    .pos   (count_t'(Y_POS)),
    .idx   (idx_y),
    .sub   (sub_y),
    .valid (valid_y)
  );

  pixel_t    pix_s1_q, pix_s1_d;
  pixel_t    pix_s2_q, pix_s2_d;
  cell_idx_t cell_x_q, cell_x_d;
  cell_idx_t cell_y_q, cell_y_d;
  logic      cell_valid_q, cell_valid_d;
  logic      line_px;
  logic      interior_px;
`ifdef BOARD_CURSOR_EN
  cell_idx_t cursor_x_q, cursor_x_d;
  cell_idx_t cursor_y_q, cursor_y_d;
  logic      cursor_hit;
`endif

  always_comb begin
    pix_s1_d = '{hcount: bus.hcount_in, vcount: bus.vcount_in,
                 hsync:  bus.hsync_in,  vsync:  bus.vsync_in,
                 hblank: bus.hblank_in, vblank: bus.vblank_in,
                 rgb:    bus.rgb_in};
`ifdef BOARD_CURSOR_EN
    cursor_x_d = cursor_x;
    cursor_y_d = cursor_y;
`endif
  end

  always_comb begin
    line_px     = valid_x && valid_y && (sub_x == '0 || sub_y == '0);
    interior_px = valid_x && valid_y && (sub_x != '0) && (sub_y != '0) &&
                  (idx_x < IDX_MAX) && (idx_y < IDX_MAX);
    pix_s2_d    = pix_s1_q;
`ifdef BOARD_CURSOR_EN
    cursor_hit  = interior_px && (idx_x == cursor_x_q) && (idx_y == cursor_y_q);
`endif
    // Priority: blanking, then grid lines, then cursor, then background.
    if (pix_s1_q.hblank || pix_s1_q.vblank) begin
      pix_s2_d.rgb = BLANK_COLOR;
    end else if (line_px) begin
      pix_s2_d.rgb = LINE_COLOR;
`ifdef BOARD_CURSOR_EN
    end else if (cursor_hit) begin
      pix_s2_d.rgb = CURSOR_COLOR;
`endif
    end
    cell_x_d     = interior_px ? idx_x : '0;
    cell_y_d     = interior_px ? idx_y : '0;
    cell_valid_d = interior_px;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_s1_q     <= '0;
      pix_s2_q     <= '0;
      cell_x_q     <= '0;
      cell_y_q     <= '0;
      cell_valid_q <= 1'b0;
`ifdef BOARD_CURSOR_EN
      cursor_x_q   <= '0;
      cursor_y_q   <= '0;
`endif
    end else begin
      pix_s1_q     <= pix_s1_d;
      pix_s2_q     <= pix_s2_d;
      cell_x_q     <= cell_x_d;
      cell_y_q     <= cell_y_d;
      cell_valid_q <= cell_valid_d;
`ifdef BOARD_CURSOR_EN
      cursor_x_q   <= cursor_x_d;
      cursor_y_q   <= cursor_y_d;
`endif
    end
  end

  assign bus.hcount_out = pix_s2_q.hcount;
  assign bus.vcount_out = pix_s2_q.vcount;
  assign bus.hsync_out  = pix_s2_q.hsync;
  assign bus.vsync_out  = pix_s2_q.vsync;
  assign bus.hblank_out = pix_s2_q.hblank;
  assign bus.vblank_out = pix_s2_q.vblank;
  assign bus.rgb_out    = pix_s2_q.rgb;
  assign bus.cell_x     = cell_x_q;
  assign bus.cell_y     = cell_y_q;
  assign bus.cell_valid = cell_valid_q;

endmodule

// File: tb/tb_draw_board_grid.sv
// Randomised pixel-stream bench for draw_board_grid with an arithmetic board model
// (division/modulo on screen coordinates) and a two-deep expected-value queue.
module tb_draw_board_grid;
  import board_pkg::*;

  localparam int X_POS = 100;
  localparam int Y_POS = 50;
  localparam int CELL  = 32;
  localparam int SPAN  = GRID_SIZE * CELL;
`ifdef BOARD_CURSOR_EN
  localparam bit CURSOR_ON = 1'b1;
`else
  localparam bit CURSOR_ON = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst;
  cell_idx_t cursor_x;
  cell_idx_t cursor_y;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];
  bit          full_line[525];

  always #5 clk = ~clk;

  draw_board_grid_if bus ();

  draw_board_grid #(
    .X_POS      (X_POS),
    .Y_POS      (Y_POS),
    .CELL_SIZE  (CELL),
    .LINE_COLOR (12'hFFF)
`ifdef BOARD_CURSOR_EN
    ,
    .CURSOR_COLOR (12'hF00)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef BOARD_CURSOR_EN
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
`endif
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(count_t hc, count_t vc, logic hs, logic vs,
                                       logic hb, logic vb, rgb_t rgb,
                                       cell_idx_t cx, cell_idx_t cy, logic cv);
    return {17'b0, hc, vc, hs, vs, hb, vb, rgb, cx, cy, cv};
  endfunction

  function automatic logic [63:0] observed();
    return pack(bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out,
                bus.hblank_out, bus.vblank_out, bus.rgb_out,
                bus.cell_x, bus.cell_y, bus.cell_valid);
  endfunction

  // What the board should look like at screen position (h, v).
  function automatic logic [63:0] model(int h, int v, logic hs, logic vs, logic hb,
                                        logic vb, rgb_t rgb, int cx, int cy);
    int   dx    = h - X_POS;
    int   dy    = v - Y_POS;
    bit   inx   = (dx >= 0) && (dx <= SPAN);
    bit   iny   = (dy >= 0) && (dy <= SPAN);
    bit   line  = inx && iny && ((dx % CELL == 0) || (dy % CELL == 0));
    bit   inter = inx && iny && !line && (dx / CELL < GRID_SIZE) && (dy / CELL < GRID_SIZE);
    rgb_t o;
    if (hb || vb)                                               o = 12'h000;
    else if (line)                                              o = 12'hFFF;
    else if (CURSOR_ON && inter && dx / CELL == cx && dy / CELL == cy) o = 12'hF00;
    else                                                        o = rgb;
    return pack(count_t'(h), count_t'(v), hs, vs, hb, vb, o,
                inter ? cell_idx_t'(dx / CELL) : cell_idx_t'(0),
                inter ? cell_idx_t'(dy / CELL) : cell_idx_t'(0), inter);
  endfunction

  function automatic logic rand_blank();
    return ($urandom_range(0, 15) == 0);
  endfunction

  task automatic drive(int h, int v, logic hs, logic vs, logic hb, logic vb,
                       rgb_t rgb, int cx, int cy);
    bus.hcount_in = count_t'(h);
    bus.vcount_in = count_t'(v);
    bus.hsync_in  = hs;
    bus.vsync_in  = vs;
    bus.hblank_in = hb;
    bus.vblank_in = vb;
    bus.rgb_in    = rgb;
    cursor_x      = cell_idx_t'(cx);
    cursor_y      = cell_idx_t'(cy);
  endtask

  // One clock: check the pixel issued two cycles ago, then issue a new one.
  task automatic pixel(int h, int v, logic hb, logic vb, rgb_t rgb, int cx, int cy);
    logic hs = 1'($urandom_range(0, 1));
    logic vs = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) check(tag_q.pop_front(), observed(), exp_q.pop_front());
    drive(h, v, hs, vs, hb, vb, rgb, cx, cy);
    exp_q.push_back(model(h, v, hs, vs, hb, vb, rgb, cx, cy));
    tag_q.push_back($sformatf("pix(%0d,%0d)", h, v));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 12'($urandom), $urandom_range(0, 15), $urandom_range(0, 15));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold%0d", i), observed(), 64'h0);
      drive($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 12'($urandom), $urandom_range(0, 15), $urandom_range(0, 15));
    end

    // Release: pipeline still holds one cleared stage, then the idle pixel below.
    rst = 1'b0;
    drive(799, 524, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 0, 0);
    exp_q.push_back(64'h0);
    tag_q.push_back("rst_release");
    exp_q.push_back(model(799, 524, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 0, 0));
    tag_q.push_back("rst_idle");

    foreach (full_line[i]) full_line[i] = 1'b0;
    foreach (full_line[i]) if (i inside {49, 50, 51, 66, 82, 119, 200, 369, 370, 371}) full_line[i] = 1'b1;
    for (int i = 0; i < 25; i++) full_line[$urandom_range(40, 380)] = 1'b1;

    for (int v = 0; v <= 390; v++) begin
      bit directed = (v inside {50, 66, 119, 200, 370});
      int cx = (v == 119) ? 3 : $urandom_range(0, 10);
      int cy = (v == 119) ? 2 : $urandom_range(0, 10);
      pixel(0, v, directed ? 1'b0 : rand_blank(), directed ? 1'b0 : rand_blank(),
            12'($urandom), cx, cy);
      pixel(50, v, (v == 200) ? 1'b1 : rand_blank(), (v == 200) ? 1'b0 : rand_blank(),
            (v == 200) ? 12'hABC : 12'($urandom), cx, cy);
      if (full_line[v]) begin
        for (int h = 98; h <= 423; h++) begin
          pixel(h, v, directed ? 1'b0 : rand_blank(), directed ? 1'b0 : rand_blank(),
                directed ? 12'h0F0 : 12'($urandom), cx, cy);
        end
      end
      pixel($urandom_range(600, 799), v, rand_blank(), rand_blank(), 12'($urandom), cx, cy);
    end

    pixel(799, 524, 1'b1, 1'b1, 12'h000, 0, 0);
    pixel(799, 524, 1'b1, 1'b1, 12'h000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
